// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: requester handshakes and memory port of the shared instruction/data memory.
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              ldr_req, ldr_we, ldr_ack;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
        output cpu_ack, ldr_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, owner
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
        input  cpu_ack, ldr_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: round-robin arbiter serialising CPU and loader accesses to a fixed-latency memory.
module mips_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    mips_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              we_q, we_d, owner_q, owner_d;
    logic              pick_ldr;

    // On a tie the grant goes to whoever did not win last time.
    assign pick_ldr = bus.ldr_req & (~bus.cpu_req | ~owner_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        owner_d = owner_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (bus.cpu_req | bus.ldr_req) begin
                owner_d = pick_ldr;
                addr_d  = pick_ldr ? bus.ldr_addr : bus.cpu_addr;
                wdata_d = pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                we_d    = pick_ldr ? bus.ldr_we : bus.cpu_we;
                cnt_d   = we_d ? 3'd1 : 3'(READ_LAT);
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d   = cnt_q - 3'd1;
                state_d = cnt_q == 3'd1 ? DONE : ACCESS;
                rdata_d = (cnt_q == 3'd1 && !we_q) ? bus.mem_rdata : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            owner_q <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            owner_q <= owner_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes and acks decode from the state so an asynchronous reset drops them at once.
    assign bus.mem_en    = state_q == ACCESS;
    assign bus.mem_we    = state_q == ACCESS && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = state_q == DONE && !owner_q;
    assign bus.ldr_ack   = state_q == DONE && owner_q;
    assign bus.rdata     = rdata_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: scoreboard bench for the arbiter at read latencies 2, 1 and 4.
module tb_mips_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {logic own; logic [31:0] rd;} exp_t;
    exp_t sb[$];

    logic [2:0] ec2 = '0, ec1 = '0, ec4 = '0;

    mips_mem_arbiter_if b2(), b1(), b4();

    mips_mem_arbiter #(.READ_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    mips_mem_arbiter #(.READ_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    mips_mem_arbiter #(.READ_LAT(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C22_0004 : a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory returns valid data only in the last cycle of its latency window.
    always @(posedge clk) begin
        ec2 <= b2.mem_en ? ec2 + 3'd1 : 3'd0;
        ec1 <= b1.mem_en ? ec1 + 3'd1 : 3'd0;
        ec4 <= b4.mem_en ? ec4 + 3'd1 : 3'd0;
    end
    assign b2.mem_rdata = ec2 == 3'd1 ? mdata(b2.mem_addr) : 32'hDEAD_BEEF;
    assign b1.mem_rdata = ec1 == 3'd0 ? mdata(b1.mem_addr) : 32'hDEAD_BEEF;
    assign b4.mem_rdata = ec4 == 3'd3 ? mdata(b4.mem_addr) : 32'hDEAD_BEEF;

    assign b1.cpu_req = b2.cpu_req;   assign b4.cpu_req = b2.cpu_req;
    assign b1.cpu_we = b2.cpu_we;     assign b4.cpu_we = b2.cpu_we;
    assign b1.cpu_addr = b2.cpu_addr; assign b4.cpu_addr = b2.cpu_addr;
    assign b1.cpu_wdata = b2.cpu_wdata; assign b4.cpu_wdata = b2.cpu_wdata;
    assign b1.ldr_req = b2.ldr_req;   assign b4.ldr_req = b2.ldr_req;
    assign b1.ldr_we = b2.ldr_we;     assign b4.ldr_we = b2.ldr_we;
    assign b1.ldr_addr = b2.ldr_addr; assign b4.ldr_addr = b2.ldr_addr;
    assign b1.ldr_wdata = b2.ldr_wdata; assign b4.ldr_wdata = b2.ldr_wdata;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({b2.cpu_ack, b2.ldr_ack, b2.mem_en, b2.mem_we} !== 4'b0) begin
            n_err++; $display("FAIL reset_strobes got %b want 0000", {b2.cpu_ack, b2.ldr_ack, b2.mem_en, b2.mem_we});
        end
        n_vec++;
        if ({b2.mem_addr, b2.mem_wdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_bus got %h want 0", {b2.mem_addr, b2.mem_wdata});
        end
        n_vec++;
        if (b2.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", b2.rdata); end
        n_vec++;
        if (b2.owner !== 1'b1) begin n_err++; $display("FAIL reset_owner got %b want 1", b2.owner); end
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        exp_t e;
        @(posedge clk); #1;
        b2.cpu_we = 1'b0; b2.cpu_addr = 32'h40; b2.cpu_req = 1'b1;
        sb.push_back({1'b0, 32'h8C22_0004});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_vec++;
            if (b2.mem_en !== (c == 1 || c == 2)) begin
                n_err++; $display("FAIL rd_mem_en c=%0d got %b want %b", c, b2.mem_en, c == 1 || c == 2);
            end
            n_vec++;
            if ({b2.cpu_ack, b2.ldr_ack} !== {c == 3, 1'b0}) begin
                n_err++; $display("FAIL rd_ack c=%0d got %b want %b", c, {b2.cpu_ack, b2.ldr_ack}, {c == 3, 1'b0});
            end
            if (b2.cpu_ack) begin
                e = sb.size() != 0 ? sb.pop_front() : 'x;
                n_vec++;
                if (b2.rdata !== e.rd) begin n_err++; $display("FAIL rd_data got %h want %h", b2.rdata, e.rd); end
                n_vec++;
                if (b2.owner !== e.own) begin n_err++; $display("FAIL rd_owner got %b want %b", b2.owner, e.own); end
                @(posedge clk); #1 b2.cpu_req = 1'b0;
            end
        end
        n_vec++;
        if (b2.rdata !== 32'h8C22_0004) begin n_err++; $display("FAIL rd_idle_hold got %h want 8c220004", b2.rdata); end
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL rd_missing_ack got %0d pending want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_ldr_write();
        exp_t e;
        @(posedge clk); #1;
        b2.ldr_we = 1'b1; b2.ldr_addr = 32'h0040_0000; b2.ldr_wdata = 32'h1234_5678; b2.ldr_req = 1'b1;
        sb.push_back({1'b1, 32'h8C22_0004});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if ({b2.mem_en, b2.mem_we} !== {c == 1, c == 1}) begin
                n_err++; $display("FAIL wr_strobe c=%0d got %b want %b", c, {b2.mem_en, b2.mem_we}, {c == 1, c == 1});
            end
            if (b2.mem_we) begin
                n_vec++;
                if ({b2.mem_addr, b2.mem_wdata} !== 64'h0040_0000_1234_5678) begin
                    n_err++; $display("FAIL wr_bus got %h want 0040000012345678", {b2.mem_addr, b2.mem_wdata});
                end
            end
            n_vec++;
            if ({b2.cpu_ack, b2.ldr_ack} !== {1'b0, c == 2}) begin
                n_err++; $display("FAIL wr_ack c=%0d got %b want %b", c, {b2.cpu_ack, b2.ldr_ack}, {1'b0, c == 2});
            end
            if (b2.ldr_ack) begin
                e = sb.size() != 0 ? sb.pop_front() : 'x;
                n_vec++;
                if (b2.rdata !== e.rd) begin n_err++; $display("FAIL wr_rdata_hold got %h want %h", b2.rdata, e.rd); end
                n_vec++;
                if (b2.owner !== e.own) begin n_err++; $display("FAIL wr_owner got %b want %b", b2.owner, e.own); end
                @(posedge clk); #1 b2.ldr_req = 1'b0;
            end
        end
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL wr_missing_ack got %0d pending want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_contention();
        exp_t e;
        int acks = 0;
        @(posedge clk); #1;
        b2.cpu_we = 1'b0; b2.cpu_addr = 32'h100; b2.ldr_we = 1'b0; b2.ldr_addr = 32'h200;
        b2.cpu_req = 1'b1; b2.ldr_req = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(i % 2 == 0 ? {1'b0, mdata(32'h100)} : {1'b1, mdata(32'h200)});
        for (int c = 0; c < 40 && acks < 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (b2.cpu_ack && b2.ldr_ack) begin n_err++; $display("FAIL rr_double_ack c=%0d got 11 want at most one", c); end
            if (b2.cpu_ack || b2.ldr_ack) begin
                e = sb.size() != 0 ? sb.pop_front() : 'x;
                acks++;
                n_vec++;
                if ({b2.cpu_ack, b2.ldr_ack} !== {~e.own, e.own}) begin
                    n_err++; $display("FAIL rr_order n=%0d got %b want %b", acks, {b2.cpu_ack, b2.ldr_ack}, {~e.own, e.own});
                end
                n_vec++;
                if (b2.owner !== e.own) begin n_err++; $display("FAIL rr_owner n=%0d got %b want %b", acks, b2.owner, e.own); end
                n_vec++;
                if (b2.rdata !== e.rd) begin n_err++; $display("FAIL rr_rdata n=%0d got %h want %h", acks, b2.rdata, e.rd); end
            end
        end
        n_vec++;
        if (acks != 4) begin n_err++; $display("FAIL rr_timeout got %0d acks want 4", acks); end
        @(posedge clk); #1 b2.cpu_req = 1'b0; b2.ldr_req = 1'b0;
        sb.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int ack_c[$];
        @(posedge clk); #1;
        b2.cpu_we = 1'b0; b2.cpu_addr = 32'h10; b2.cpu_req = 1'b1;
        sb.push_back({1'b0, mdata(32'h10)});
        for (int c = 0; c < 30 && ack_c.size() < 3; c++) begin
            @(negedge clk);
            if (b2.cpu_ack) begin
                e = sb.size() != 0 ? sb.pop_front() : 'x;
                ack_c.push_back(c);
                n_vec++;
                if (b2.rdata !== e.rd) begin n_err++; $display("FAIL b2b_rdata c=%0d got %h want %h", c, b2.rdata, e.rd); end
                n_vec++;
                if (b2.owner !== 1'b0) begin n_err++; $display("FAIL b2b_owner c=%0d got %b want 0", c, b2.owner); end
                @(posedge clk); #1;
                if (ack_c.size() < 3) begin
                    b2.cpu_addr = b2.cpu_addr + 32'd4;
                    sb.push_back({1'b0, mdata(b2.cpu_addr)});
                end else b2.cpu_req = 1'b0;
            end
        end
        n_vec++;
        if (ack_c.size() != 3) begin n_err++; $display("FAIL b2b_timeout got %0d acks want 3", ack_c.size()); end
        else begin
            n_vec++;
            if (ack_c[0] != 3) begin n_err++; $display("FAIL b2b_first got cycle %0d want 3", ack_c[0]); end
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (ack_c[i] - ack_c[i-1] != 4) begin
                    n_err++; $display("FAIL b2b_spacing got %0d want 4", ack_c[i] - ack_c[i-1]);
                end
            end
        end
        b2.cpu_req = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int acks = 0;
        @(posedge clk); #1;
        b2.cpu_we = 1'b0; b2.cpu_addr = 32'h80; b2.cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (b2.mem_en !== 1'b1) begin n_err++; $display("FAIL abort_pre_en got %b want 1", b2.mem_en); end
        #2 rst = 1'b1; b2.cpu_req = 1'b0;
        #1;
        n_vec++;
        if ({b2.mem_en, b2.mem_we, b2.cpu_ack, b2.ldr_ack} !== 4'b0) begin
            n_err++; $display("FAIL abort_async got %b want 0000", {b2.mem_en, b2.mem_we, b2.cpu_ack, b2.ldr_ack});
        end
        n_vec++;
        if (b2.owner !== 1'b1) begin n_err++; $display("FAIL abort_owner got %b want 1", b2.owner); end
        @(negedge clk) rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (b2.cpu_ack || b2.ldr_ack) acks++;
        end
        n_vec++;
        if (acks != 0) begin n_err++; $display("FAIL abort_ghost_ack got %0d want 0", acks); end
        @(posedge clk); #1;
        b2.cpu_addr = 32'h44; b2.cpu_req = 1'b1;
        sb.push_back({1'b0, mdata(32'h44)});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_vec++;
            if (b2.cpu_ack !== (c == 3)) begin n_err++; $display("FAIL abort_next_ack c=%0d got %b want %b", c, b2.cpu_ack, c == 3); end
            if (b2.cpu_ack) begin
                e = sb.size() != 0 ? sb.pop_front() : 'x;
                n_vec++;
                if (b2.rdata !== e.rd) begin n_err++; $display("FAIL abort_next_rdata got %h want %h", b2.rdata, e.rd); end
                @(posedge clk); #1 b2.cpu_req = 1'b0;
            end
        end
        sb.delete();
    endtask

    task automatic test_latency();
        int c1 = -1, c4 = -1;
        logic [31:0] r1 = '0, r4 = '0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        b2.cpu_we = 1'b0; b2.cpu_addr = 32'hC0; b2.cpu_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b1.cpu_ack && c1 < 0) begin c1 = c; r1 = b1.rdata; end
            if (b4.cpu_ack && c4 < 0) begin c4 = c; r4 = b4.rdata; end
            if (c4 >= 0 && b2.cpu_req) begin @(posedge clk); #1 b2.cpu_req = 1'b0; end
        end
        b2.cpu_req = 1'b0;
        n_vec++;
        if (c1 != 2) begin n_err++; $display("FAIL lat1_cycle got %0d want 2", c1); end
        n_vec++;
        if (c4 != 5) begin n_err++; $display("FAIL lat4_cycle got %0d want 5", c4); end
        n_vec++;
        if (r1 !== mdata(32'hC0)) begin n_err++; $display("FAIL lat1_rdata got %h want %h", r1, mdata(32'hC0)); end
        n_vec++;
        if (r4 !== mdata(32'hC0)) begin n_err++; $display("FAIL lat4_rdata got %h want %h", r4, mdata(32'hC0)); end
    endtask

    initial begin
        b2.cpu_req = 1'b0; b2.cpu_we = 1'b0; b2.cpu_addr = '0; b2.cpu_wdata = '0;
        b2.ldr_req = 1'b0; b2.ldr_we = 1'b0; b2.ldr_addr = '0; b2.ldr_wdata = '0;
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_contention();
        test_back_to_back();
        test_reset_abort();
        test_latency();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
